// File: rtl/raw10_pkg.sv
// ---------------------------------------------------------------------------
// raw10_pkg
// Shared constants, the serializer state type and a lane-select helper for
// the RAW10 pixel serializer.
//   PIX_W        : bits per RAW10 pixel
//   QUAD_W       : bits per four-pixel group from the unpacker
//   PIX_PER_QUAD : pixels carried by one quad
//   COORD_W      : width of the x/y coordinate outputs
// ---------------------------------------------------------------------------
package raw10_pkg;

   localparam int PIX_W        = 10;
   localparam int QUAD_W       = 40;
   localparam int PIX_PER_QUAD = 4;
   localparam int COORD_W      = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Pixel 0 sits in the most significant field of the quad.
   function automatic logic [PIX_W-1:0] quad_pixel(input logic [QUAD_W-1:0] quad,
                                                   input logic [1:0]        lane);
      logic [PIX_W-1:0] pix;
      case (lane)
         2'd0:    pix = quad[QUAD_W-1           -: PIX_W];
         2'd1:    pix = quad[QUAD_W-1 - PIX_W   -: PIX_W];
         2'd2:    pix = quad[QUAD_W-1 - 2*PIX_W -: PIX_W];
         default: pix = quad[QUAD_W-1 - 3*PIX_W -: PIX_W];
      endcase
      return pix;
   endfunction

endpackage

// File: rtl/raw10_quad_fifo.sv
// ---------------------------------------------------------------------------
// raw10_quad_fifo
// Synchronous first-word-fall-through FIFO for 40-bit RAW10 quads.
// The head entry is always presented on dout_o so the serializer can load it
// in the same cycle it pops. Full/empty are registered from the next
// occupancy count.
// Ports:
//   clk_i, reset_n : clock, asynchronous active-low reset
//   wr_en_i, din_i : push a quad (caller guarantees not full, unless popping)
//   rd_en_i        : pop the head (caller guarantees not empty)
//   dout_o         : head of the FIFO
//   full_o/empty_o : registered status
//   count_o        : occupancy, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module raw10_quad_fifo
   import raw10_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk_i,
   input  logic              reset_n,
   input  logic              wr_en_i,
   input  logic [QUAD_W-1:0] din_i,
   input  logic              rd_en_i,
   output logic [QUAD_W-1:0] dout_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CW-1:0]     count_o
);

   logic [QUAD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic              full_q;
   logic              empty_q;

   always_comb begin
      count_d = count_q + CW'(wr_en_i) - CW'(rd_en_i);
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/raw10_pixel_serializer.sv
// ---------------------------------------------------------------------------
// raw10_pixel_serializer
// Buffers 40-bit RAW10 quads from the unpacker (no backpressure) and emits
// one 10-bit pixel per valid/ready handshake, tagged with x/y coordinates and
// start-of-frame / end-of-line / end-of-frame flags.
// Ports:
//   clk_i, reset_n             : pixel clock, asynchronous active-low reset
//   data_valid_i, data_i       : quad strobe and quad (pixel0 in [39:30])
//   fifo_full_o                : FIFO holds FIFO_DEPTH quads
//   overflow_o                 : sticky, a quad was dropped
//   clear_i                    : clears overflow_o and the x/y counters
//   pixel_valid_o/pixel_ready_i: output handshake
//   pixel_o, x_o, y_o          : pixel and its coordinates
//   sof_o, eol_o, eof_o        : flags, qualified by pixel_valid_o
// Optional build macro RAW10_SER_STATS_EN adds frame_count_o and drop_count_o.
// ---------------------------------------------------------------------------
module raw10_pixel_serializer
   import raw10_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int LINE_WIDTH   = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic               clk_i,
   input  logic               reset_n,
   input  logic               data_valid_i,
   input  logic [QUAD_W-1:0]  data_i,
   output logic               fifo_full_o,
   output logic               overflow_o,
   input  logic               clear_i,
   output logic               pixel_valid_o,
   input  logic               pixel_ready_i,
   output logic [PIX_W-1:0]   pixel_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               sof_o,
   output logic               eol_o,
   output logic               eof_o
`ifdef RAW10_SER_STATS_EN
   ,output logic [15:0]       frame_count_o
   ,output logic [15:0]       drop_count_o
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(LINE_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_HEIGHT - 1);

   logic              fifo_wr;
   logic              fifo_rd;
   logic              fifo_full;
   logic              fifo_empty;
   logic [QUAD_W-1:0] fifo_dout;
   logic [CW-1:0]     fifo_count;
   logic              fifo_count_unused;
   logic              fifo_has_data;

   ser_state_e        state_q;
   logic [QUAD_W-1:0] quad_q;
   logic [1:0]        lane_q;
   logic              pixel_valid_q;
   logic [PIX_W-1:0]  pixel_q;
   logic              valid_d;

   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               sof_q, eol_q, eof_q;
   logic               overflow_q;

   logic handshake;
   logic last_lane;
   logic drop;

   raw10_quad_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .wr_en_i (fifo_wr),
      .din_i   (data_i),
      .rd_en_i (fifo_rd),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Occupancy is only needed inside the FIFO for its full flag.
   assign fifo_count_unused = ^fifo_count;

   assign fifo_has_data = !fifo_empty;
   assign handshake     = pixel_valid_q && pixel_ready_i;
   assign last_lane     = (lane_q == 2'd3);
   // Pop when idle, or when the last lane of the current quad is consumed.
   assign fifo_rd       = fifo_has_data && ((state_q == IDLE) || (handshake && last_lane));
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign fifo_wr       = data_valid_i && (!fifo_full || fifo_rd);
   assign drop          = data_valid_i && fifo_full && !fifo_rd;

   // Validity of the pixel presented next cycle; gates the registered flags.
   always_comb begin
      valid_d = pixel_valid_q;
      if (state_q == IDLE) begin
         valid_d = fifo_has_data;
      end else if (handshake && last_lane && !fifo_has_data) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         quad_q        <= '0;
         lane_q        <= 2'd0;
         pixel_valid_q <= 1'b0;
         pixel_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fifo_has_data) begin
                  quad_q        <= fifo_dout;
                  lane_q        <= 2'd0;
                  pixel_q       <= quad_pixel(fifo_dout, 2'd0);
                  pixel_valid_q <= 1'b1;
                  state_q       <= SHIFT;
               end
            end
            SHIFT: begin
               if (handshake) begin
                  if (last_lane) begin
                     if (fifo_has_data) begin
                        // Chain straight into the next quad: no bubble.
                        quad_q  <= fifo_dout;
                        lane_q  <= 2'd0;
                        pixel_q <= quad_pixel(fifo_dout, 2'd0);
                     end else begin
                        pixel_valid_q <= 1'b0;
                        state_q       <= IDLE;
                     end
                  end else begin
                     lane_q  <= lane_q + 2'd1;
                     pixel_q <= quad_pixel(quad_q, lane_q + 2'd1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Coordinates name the pixel on pixel_o; clear beats a same-cycle advance.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear_i) begin
         x_d = '0;
         y_d = '0;
      end else if (handshake) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         x_q        <= '0;
         y_q        <= '0;
         sof_q      <= 1'b0;
         eol_q      <= 1'b0;
         eof_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         sof_q      <= valid_d && (x_d == '0) && (y_d == '0);
         eol_q      <= valid_d && (x_d == X_LAST);
         eof_q      <= valid_d && (x_d == X_LAST) && (y_d == Y_LAST);
         overflow_q <= clear_i ? 1'b0 : (overflow_q | drop);
      end
   end

`ifdef RAW10_SER_STATS_EN
   logic [15:0] frame_count_q;
   logic [15:0] drop_count_q;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         frame_count_q <= '0;
         drop_count_q  <= '0;
      end else if (clear_i) begin
         frame_count_q <= '0;
         drop_count_q  <= '0;
      end else begin
         if (handshake && eof_q) frame_count_q <= frame_count_q + 16'd1;
         if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      end
   end

   assign frame_count_o = frame_count_q;
   assign drop_count_o  = drop_count_q;
`endif

   assign fifo_full_o   = fifo_full;
   assign overflow_o    = overflow_q;
   assign pixel_valid_o = pixel_valid_q;
   assign pixel_o       = pixel_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign sof_o         = sof_q;
   assign eol_o         = eol_q;
   assign eof_o         = eof_q;

endmodule

// File: tb/tb_raw10_pixel_serializer.sv
// ---------------------------------------------------------------------------
// tb_raw10_pixel_serializer
// Self-checking bench for raw10_pixel_serializer with a small 8x2 frame.
// Expected pixels are kept as a queue of values; coordinates and flags are
// derived arithmetically from the count of pixels accepted since clear/reset.
// ---------------------------------------------------------------------------
module tb_raw10_pixel_serializer;

   localparam int FIFO_DEPTH = 4;
   localparam int LW         = 8;
   localparam int FH         = 2;

   logic        clk_i = 1'b0;
   logic        reset_n = 1'b0;
   logic        data_valid_i;
   logic [39:0] data_i;
   logic        fifo_full_o;
   logic        overflow_o;
   logic        clear_i;
   logic        pixel_valid_o;
   logic        pixel_ready_i;
   logic [9:0]  pixel_o;
   logic [15:0] x_o;
   logic [15:0] y_o;
   logic        sof_o, eol_o, eof_o;
`ifdef RAW10_SER_STATS_EN
   logic [15:0] frame_count_o;
   logic [15:0] drop_count_o;
`endif

   raw10_pixel_serializer #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .LINE_WIDTH   (LW),
      .FRAME_HEIGHT (FH)
   ) dut (
      .clk_i         (clk_i),
      .reset_n       (reset_n),
      .data_valid_i  (data_valid_i),
      .data_i        (data_i),
      .fifo_full_o   (fifo_full_o),
      .overflow_o    (overflow_o),
      .clear_i       (clear_i),
      .pixel_valid_o (pixel_valid_o),
      .pixel_ready_i (pixel_ready_i),
      .pixel_o       (pixel_o),
      .x_o           (x_o),
      .y_o           (y_o),
      .sof_o         (sof_o),
      .eol_o         (eol_o),
      .eof_o         (eof_o)
`ifdef RAW10_SER_STATS_EN
      ,.frame_count_o (frame_count_o)
      ,.drop_count_o  (drop_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int         vec = 0;
   int         errs = 0;
   logic [9:0] exp_pix[$];
   int         n_pix = 0;
   int         hs_total = 0;
   int         sent_quads = 0;
   int         frames_model = 0;
   bit         sb_en = 1'b0;

   // Scoreboard state
   bit          prev_hold = 1'b0;
   logic [45:0] held;
   logic [9:0]  mon_p;
   int          mon_x, mon_y;
   bit          mon_hs, mon_eof;

   function automatic logic [9:0] pix_of(input logic [39:0] q, input int k);
      logic [39:0] t;
      t = q << (10 * k);
      return t[39:30];
   endfunction

   function automatic logic [39:0] rand_quad();
      return {8'($urandom()), $urandom()};
   endfunction

   task automatic push_quad(input logic [39:0] q);
      for (int k = 0; k < 4; k++) exp_pix.push_back(pix_of(q, k));
      sent_quads++;
   endtask

   task automatic cyc(input logic dv, input logic [39:0] d, input logic rdy, input logic clr);
      @(posedge clk_i);
      #1;
      data_valid_i  = dv;
      data_i        = d;
      pixel_ready_i = rdy;
      clear_i       = clr;
      @(negedge clk_i);
   endtask

   task automatic drain(output bit ok);
      int n;
      n = 0;
      while (exp_pix.size() != 0 && n < 300) begin
         cyc(1'b0, 40'd0, 1'b1, 1'b0);
         n++;
      end
      cyc(1'b0, 40'd0, 1'b1, 1'b0);
      ok = (exp_pix.size() == 0);
   endtask

   // Stream scoreboard: every handshake is checked against the expected
   // pixel order and the coordinate/flag rules; held outputs must not move.
   always @(negedge clk_i) begin
      if (!reset_n) begin
         prev_hold = 1'b0;
      end else if (sb_en) begin
         mon_hs  = pixel_valid_o && pixel_ready_i;
         mon_x   = n_pix % LW;
         mon_y   = (n_pix / LW) % FH;
         mon_eof = (mon_x == LW - 1) && (mon_y == FH - 1);
         if (prev_hold) begin
            vec++;
            if ({pixel_o, x_o, y_o, sof_o, eol_o, eof_o, pixel_valid_o} !== held) begin
               errs++;
               $display("FAIL stall_hold: got %h, want %h", {pixel_o, x_o, y_o, sof_o, eol_o, eof_o, pixel_valid_o}, held);
            end
         end
         if (mon_hs) begin
            vec++;
            if (exp_pix.size() == 0) begin
               errs++;
               $display("FAIL unexpected_pixel: got pixel %h at x=%0d, want no pixel", pixel_o, x_o);
            end else begin
               mon_p = exp_pix.pop_front();
               if (pixel_o !== mon_p || x_o !== 16'(mon_x) || y_o !== 16'(mon_y) ||
                   sof_o !== (mon_x == 0 && mon_y == 0) || eol_o !== (mon_x == LW - 1) || eof_o !== mon_eof) begin
                  errs++;
                  $display("FAIL stream_pixel: got pix=%h x=%0d y=%0d sof=%b eol=%b eof=%b, want pix=%h x=%0d y=%0d sof=%b eol=%b eof=%b",
                           pixel_o, x_o, y_o, sof_o, eol_o, eof_o, mon_p, mon_x, mon_y,
                           (mon_x == 0 && mon_y == 0), (mon_x == LW - 1), mon_eof);
               end
            end
            hs_total++;
         end
         if (clear_i) begin
            n_pix        = 0;
            frames_model = 0;
         end else if (mon_hs) begin
            n_pix++;
            if (mon_eof) frames_model++;
         end
         prev_hold = pixel_valid_o && !pixel_ready_i && !clear_i;
         held      = {pixel_o, x_o, y_o, sof_o, eol_o, eof_o, pixel_valid_o};
      end
   end

   task automatic test_reset();
      data_valid_i  = 1'b0;
      data_i        = '0;
      pixel_ready_i = 1'b0;
      clear_i       = 1'b0;
      reset_n       = 1'b0;
      repeat (3) @(negedge clk_i);
      vec++;
      if ({pixel_valid_o, sof_o, eol_o, eof_o, fifo_full_o, overflow_o} !== 6'b0) begin
         errs++;
         $display("FAIL reset_flags: got %b, want 000000", {pixel_valid_o, sof_o, eol_o, eof_o, fifo_full_o, overflow_o});
      end
      vec++;
      if (pixel_o !== 10'd0) begin errs++; $display("FAIL reset_pixel: got %h, want 000", pixel_o); end
      vec++;
      if (x_o !== 16'd0 || y_o !== 16'd0) begin errs++; $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", x_o, y_o); end
`ifdef RAW10_SER_STATS_EN
      vec++;
      if (frame_count_o !== 16'd0 || drop_count_o !== 16'd0) begin
         errs++; $display("FAIL reset_stats: got %0d %0d, want 0 0", frame_count_o, drop_count_o);
      end
`endif
      @(posedge clk_i);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_single_quad();
      logic [39:0] q;
      q = {10'h3FF, 10'h001, 10'h200, 10'h155};
      push_quad(q);
      cyc(1'b1, q, 1'b1, 1'b0);
      vec++;
      if (pixel_valid_o !== 1'b0) begin errs++; $display("FAIL latency_n: got valid=%b, want 0", pixel_valid_o); end
      cyc(1'b0, 40'd0, 1'b1, 1'b0);
      vec++;
      if (pixel_valid_o !== 1'b0) begin errs++; $display("FAIL latency_n1: got valid=%b, want 0", pixel_valid_o); end
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 40'd0, 1'b1, 1'b0);
         vec++;
         if (pixel_valid_o !== 1'b1 || pixel_o !== pix_of(q, k) || x_o !== 16'(k) || y_o !== 16'd0 || sof_o !== (k == 0)) begin
            errs++;
            $display("FAIL single_quad_%0d: got v=%b pix=%h x=%0d y=%0d sof=%b, want v=1 pix=%h x=%0d y=0 sof=%b",
                     k, pixel_valid_o, pixel_o, x_o, y_o, sof_o, pix_of(q, k), k, (k == 0));
         end
      end
      cyc(1'b0, 40'd0, 1'b1, 1'b0);
      vec++;
      if (pixel_valid_o !== 1'b0) begin errs++; $display("FAIL single_quad_end: got valid=%b, want 0", pixel_valid_o); end
   endtask

   task automatic test_frame_flags();
      logic [39:0] qs[5];
      int h;
      cyc(1'b0, 40'd0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         qs[i] = rand_quad();
         push_quad(qs[i]);
      end
      for (int c = 0; c < 24; c++) begin
         cyc(c < 5, (c < 5) ? qs[c % 5] : 40'd0, 1'b1, 1'b0);
         if (c >= 2 && c <= 21) begin
            h = c - 1;
            vec++;
            if (pixel_valid_o !== 1'b1 || sof_o !== (h == 1 || h == 17) || eol_o !== (h % 8 == 0) || eof_o !== (h == 16)) begin
               errs++;
               $display("FAIL frame_flags_%0d: got v=%b sof=%b eol=%b eof=%b, want v=1 sof=%b eol=%b eof=%b",
                        h, pixel_valid_o, sof_o, eol_o, eof_o, (h == 1 || h == 17), (h % 8 == 0), (h == 16));
            end
         end else if (c == 22) begin
            vec++;
            if (pixel_valid_o !== 1'b0) begin errs++; $display("FAIL frame_end_idle: got valid=%b, want 0", pixel_valid_o); end
         end
      end
`ifdef RAW10_SER_STATS_EN
      vec++;
      if (frame_count_o !== 16'd1) begin errs++; $display("FAIL frame_count: got %0d, want 1", frame_count_o); end
`endif
   endtask

   task automatic test_stall();
      logic [39:0] q;
      int base, hs0;
      bit ok;
      q    = rand_quad();
      base = n_pix;
      hs0  = hs_total;
      push_quad(q);
      cyc(1'b1, q, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 40'd0, 1'b1, 1'b0);
      for (int s = 0; s < 5; s++) begin
         cyc(1'b0, 40'd0, 1'b0, 1'b0);
         vec++;
         if (pixel_valid_o !== 1'b1 || pixel_o !== pix_of(q, 2) || x_o !== 16'((base + 2) % LW) || y_o !== 16'(((base + 2) / LW) % FH)) begin
            errs++;
            $display("FAIL stall_%0d: got v=%b pix=%h x=%0d y=%0d, want v=1 pix=%h x=%0d y=%0d", s, pixel_valid_o, pixel_o, x_o, y_o,
                     pix_of(q, 2), (base + 2) % LW, ((base + 2) / LW) % FH);
         end
      end
      drain(ok);
      vec++;
      if (!ok || hs_total - hs0 != 4) begin
         errs++; $display("FAIL stall_count: got %0d pixels, %0d left, want 4 pixels, 0 left", hs_total - hs0, exp_pix.size());
      end
   endtask

   task automatic test_overflow();
      logic [39:0] q;
      for (int k = 0; k < 6; k++) begin
         q = rand_quad();
         if (k < 5) push_quad(q);
         cyc(1'b1, q, 1'b0, 1'b0);
         if (k == 4) begin
            vec++;
            if (fifo_full_o !== 1'b0) begin errs++; $display("FAIL full_early: got %b, want 0", fifo_full_o); end
         end
         if (k == 5) begin
            vec++;
            if (fifo_full_o !== 1'b1 || overflow_o !== 1'b0) begin
               errs++; $display("FAIL full_set: got full=%b ovf=%b, want full=1 ovf=0", fifo_full_o, overflow_o);
            end
         end
      end
      cyc(1'b0, 40'd0, 1'b0, 1'b0);
      vec++;
      if (overflow_o !== 1'b1 || fifo_full_o !== 1'b1) begin
         errs++; $display("FAIL overflow_set: got ovf=%b full=%b, want 1 1", overflow_o, fifo_full_o);
      end
`ifdef RAW10_SER_STATS_EN
      vec++;
      if (drop_count_o !== 16'd1) begin errs++; $display("FAIL drop_count: got %0d, want 1", drop_count_o); end
`endif
   endtask

   task automatic test_full_pop();
      logic [39:0] q;
      bit ok;
      cyc(1'b0, 40'd0, 1'b0, 1'b1);
      cyc(1'b0, 40'd0, 1'b1, 1'b0);
      vec++;
      if (overflow_o !== 1'b0) begin errs++; $display("FAIL overflow_clear: got %b, want 0", overflow_o); end
`ifdef RAW10_SER_STATS_EN
      vec++;
      if (drop_count_o !== 16'd0) begin errs++; $display("FAIL drop_count_clear: got %0d, want 0", drop_count_o); end
`endif
      repeat (2) cyc(1'b0, 40'd0, 1'b1, 1'b0);
      q = rand_quad();
      push_quad(q);
      cyc(1'b1, q, 1'b1, 1'b0);
      vec++;
      if (fifo_full_o !== 1'b1 || pixel_valid_o !== 1'b1) begin
         errs++; $display("FAIL full_pop_setup: got full=%b v=%b, want 1 1", fifo_full_o, pixel_valid_o);
      end
      cyc(1'b0, 40'd0, 1'b1, 1'b0);
      vec++;
      if (overflow_o !== 1'b0 || fifo_full_o !== 1'b1) begin
         errs++; $display("FAIL full_pop_accept: got ovf=%b full=%b, want ovf=0 full=1", overflow_o, fifo_full_o);
      end
      drain(ok);
      vec++;
      if (!ok) begin errs++; $display("FAIL full_pop_drain: got %0d pixels left, want 0", exp_pix.size()); end
   endtask

   task automatic test_random();
      logic [39:0] q;
      logic dv, rdy, clr;
      bit ok;
      for (int c = 0; c < 600; c++) begin
         dv  = ($urandom_range(0, 1) == 1) && ((sent_quads - hs_total / 4) < FIFO_DEPTH);
         rdy = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 63) == 0);
         q   = rand_quad();
         if (dv) push_quad(q);
         cyc(dv, q, rdy, clr);
      end
      drain(ok);
      vec++;
      if (!ok || hs_total != 4 * sent_quads) begin
         errs++; $display("FAIL random_drain: got %0d pixels, %0d left, want %0d pixels, 0 left", hs_total, exp_pix.size(), 4 * sent_quads);
      end
   endtask

   task automatic test_async_reset();
      logic [39:0] q;
      bit ok;
      q = rand_quad();
      push_quad(q);
      cyc(1'b1, q, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 40'd0, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      vec++;
      if ({pixel_valid_o, sof_o, eol_o, eof_o, fifo_full_o, overflow_o} !== 6'b0 || pixel_o !== 10'd0 || x_o !== 16'd0 || y_o !== 16'd0) begin
         errs++;
         $display("FAIL async_reset: got v=%b pix=%h x=%0d y=%0d flags=%b, want all 0", pixel_valid_o, pixel_o, x_o, y_o,
                  {sof_o, eol_o, eof_o, fifo_full_o, overflow_o});
      end
      exp_pix.delete();
      n_pix        = 0;
      frames_model = 0;
      sent_quads   = 0;
      hs_total     = 0;
      @(posedge clk_i);
      #1 reset_n = 1'b1;
      q = rand_quad();
      push_quad(q);
      cyc(1'b1, q, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, 40'd0, 1'b1, 1'b0);
      vec++;
      if (pixel_valid_o !== 1'b1 || pixel_o !== pix_of(q, 0) || x_o !== 16'd0 || y_o !== 16'd0 || sof_o !== 1'b1) begin
         errs++;
         $display("FAIL post_reset_first: got v=%b pix=%h x=%0d y=%0d sof=%b, want v=1 pix=%h x=0 y=0 sof=1",
                  pixel_valid_o, pixel_o, x_o, y_o, sof_o, pix_of(q, 0));
      end
      drain(ok);
      vec++;
      if (!ok) begin errs++; $display("FAIL post_reset_drain: got %0d pixels left, want 0", exp_pix.size()); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      sb_en = 1'b1;
      test_single_quad();
      test_frame_flags();
      test_stall();
      test_overflow();
      test_full_pop();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
